// File: rtl/softmax_stream.sv
// Streaming softmax: loads N signed logits, turns max-subtracted differences into exponentials
// via a 256-entry LUT, accumulates their sum, then divides each term serially (one quotient bit
// per cycle) and streams the N probabilities out under valid/ready.
// Optional feature: define SOFTMAX_ARGMAX_EN to add the out_argmax port and its register.
module softmax_stream #(
  parameter int unsigned N    = 10,
  parameter int unsigned IW   = 16,
  parameter int unsigned FRAC = 8,
  parameter int unsigned OW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [$clog2(N)-1:0] out_argmax
`endif
);

  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned SW  = OW + CW;
  localparam int unsigned BW  = (IW > OW) ? IW : OW;
  localparam int unsigned DW  = IW + 1;
  localparam int unsigned DCW = $clog2(OW);
  localparam logic [DW-1:0] DLim = DW'(16) << FRAC;

  localparam logic [1:0] StLoad = 2'd0;
  localparam logic [1:0] StExp  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  // round((2^OW-1) * exp(-j/16)) in Q60 integer arithmetic, evaluated at elaboration only
  function automatic logic [OW-1:0] exp_lut(input int unsigned j);
    logic [127:0] one, term, pos, neg, base, res;
    one  = 128'd1 << 60;
    term = one;
    pos  = one;
    neg  = '0;
    for (int k = 1; k < 24; k++) begin
      term = term / (128'd16 * 128'(k));
      if ((k % 2) == 1) neg = neg + term;
      else pos = pos + term;
    end
    base = pos - neg;
    res  = one;
    for (int b = 0; b < 8; b++) begin
      if (j[b]) res = (res * base) >> 60;
      base = (base * base) >> 60;
    end
    return OW'((res * ((128'd1 << OW) - 128'd1) + (128'd1 << 59)) >> 60);
  endfunction

  logic [OW-1:0] lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [OW-1:0] LutVal = exp_lut(g);
    assign lut[g] = LutVal;
  end

  logic [1:0]           st_q, st_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic signed [IW-1:0] max_q, max_d;
  logic [CW-1:0]        arg_q, arg_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [SW-1:0]        rem_q, rem_d;
  logic [OW-1:0]        quo_q, quo_d;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic [BW-1:0]        mem_q [N];
  logic [BW-1:0]        mem_d [N];
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OW-1:0]        out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [CW-1:0]        argmax_q, argmax_d;

  logic [IW-1:0]        cur;
  logic [DW-1:0]        diff;
  logic [OW-1:0]        e;
  logic [SW:0]          rem2;
  logic                 ge;
  logic [SW-1:0]        rem_nxt;
  logic [OW-1:0]        quo_nxt;

  // Next-state logic: load/max tracking, LUT exponentials, restoring divide, output handshake
  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    arg_d       = arg_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dcnt_d      = dcnt_q;
    mem_d       = mem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    argmax_d    = argmax_q;
    cnt_inc     = cnt_q + 1'b1;

    // d = max - x is never negative; anything at or beyond 16.0 underflows the LUT to zero
    cur     = mem_q[cnt_q][IW-1:0];
    diff    = {max_q[IW-1], max_q} - {cur[IW-1], cur};
    e       = (diff >= DLim) ? '0 : lut[diff[FRAC+3:FRAC-4]];

    // e <= sum always holds, so e == sum saturates naturally to all ones
    rem2    = {rem_q, 1'b0};
    ge      = rem2 >= {1'b0, sum_q};
    rem_nxt = ge ? SW'(rem2 - {1'b0, sum_q}) : SW'(rem2);
    quo_nxt = {quo_q[OW-2:0], ge};

    unique case (st_q)
      StLoad: begin
        if (in_valid && in_ready_q) begin
          mem_d[cnt_q] = BW'(in_data);
          // strict compare keeps the lowest index on ties
          if (cnt_q == '0 || $signed(in_data) > max_q) begin
            max_d = $signed(in_data);
            arg_d = cnt_q;
          end
          if (cnt_q == CW'(N - 1)) begin
            st_d     = StExp;
            cnt_d    = '0;
            sum_d    = '0;
            argmax_d = arg_d;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StExp: begin
        mem_d[cnt_q] = BW'(e);
        sum_d        = sum_q + SW'(e);
        if (cnt_q == CW'(N - 1)) begin
          st_d   = StDiv;
          cnt_d  = '0;
          rem_d  = SW'(mem_q[0][OW-1:0]);
          dcnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDiv: begin
        rem_d  = rem_nxt;
        quo_d  = quo_nxt;
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DCW'(OW - 1)) begin
          st_d        = StOut;
          out_valid_d = 1'b1;
          out_data_d  = quo_nxt;
          out_last_d  = (cnt_q == CW'(N - 1));
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == CW'(N - 1)) begin
            st_d  = StLoad;
            cnt_d = '0;
          end else begin
            st_d   = StDiv;
            cnt_d  = cnt_inc;
            rem_d  = SW'(mem_q[cnt_inc][OW-1:0]);
            dcnt_d = '0;
          end
        end
      end
      default: st_d = StLoad;
    endcase

    in_ready_d = (st_d == StLoad);
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StLoad;
      cnt_q       <= '0;
      max_q       <= '0;
      arg_q       <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      argmax_q    <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      arg_q       <= arg_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dcnt_q      <= dcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      argmax_q    <= argmax_d;
    end
  end

  // Vector buffer: deliberately not reset, every slot is rewritten before it is read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef SOFTMAX_ARGMAX_EN
  assign out_argmax = argmax_q;
`else
  logic unused_argmax;
  assign unused_argmax = ^argmax_q;
`endif

endmodule

// File: tb/tb_softmax_stream.sv
// Directed bench for softmax_stream: one N=4 and one N=2 instance share clock, reset and
// out_ready; sel4 steers the input stream and the observed outputs to one of them.
module tb_softmax_stream;
  localparam int unsigned OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, sel4;
  logic [15:0] in_data;
  logic        in_ready4, out_valid4, out_last4;
  logic        in_ready2, out_valid2, out_last2;
  logic [15:0] out_data4, out_data2;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic [15:0] out_data_m;
  int          n_chk = 0;
  int          n_pass = 0;
`ifdef SOFTMAX_ARGMAX_EN
  logic [1:0]  argmax4;
  logic [0:0]  argmax2;
  logic [1:0]  argmax_m;
  assign argmax_m = sel4 ? argmax4 : {1'b0, argmax2};
`endif

  softmax_stream #(.N(4), .IW(16), .FRAC(8), .OW(OW)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel4), .in_data(in_data),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_last(out_last4), .out_ready(out_ready)
`ifdef SOFTMAX_ARGMAX_EN
    , .out_argmax(argmax4)
`endif
  );

  softmax_stream #(.N(2), .IW(16), .FRAC(8), .OW(OW)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel4), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_last(out_last2), .out_ready(out_ready)
`ifdef SOFTMAX_ARGMAX_EN
    , .out_argmax(argmax2)
`endif
  );

  assign in_ready_m  = sel4 ? in_ready4  : in_ready2;
  assign out_valid_m = sel4 ? out_valid4 : out_valid2;
  assign out_data_m  = sel4 ? out_data4  : out_data2;
  assign out_last_m  = sel4 ? out_last4  : out_last2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Push n logits back to back; the edge accepting the last one is the final tick here
  task automatic send(input int n, input logic [15:0] v [4]);
    for (int i = 0; i < n; i++) begin
      check("in_ready_load", 32'(in_ready_m), 32'd1);
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
    end
    in_valid = 1'b0;
    check("in_ready_fall", 32'(in_ready_m), 32'd0);
  endtask

  // Collect elements 0..stop-1. Latency counts edges: N+OW after the last accept for element
  // 0, and OW after each handshake edge (OW+1 cycles counting the handshake cycle itself).
  task automatic recv(input int n, input int stop, input logic [15:0] e [4], input int exp_arg,
                      input int stall_at, input int stall_len);
    for (int i = 0; i < stop; i++) begin
      int lat = 0;
      while (!out_valid_m && lat < 200) begin
        tick();
        lat++;
      end
      check(i == 0 ? "lat_first" : "hs_to_valid", 32'(lat), (i == 0) ? 32'(n + OW) : 32'(OW));
      check("data", 32'(out_data_m), 32'(e[i]));
      check("last", 32'(out_last_m), 32'(i == n - 1));
`ifdef SOFTMAX_ARGMAX_EN
      check("argmax", 32'(argmax_m), 32'(exp_arg));
`endif
      if (i == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;  // must be ignored while processing
        in_data   = 16'h7fff;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_valid", 32'(out_valid_m), 32'd1);
          check("stall_data", 32'(out_data_m), 32'(e[i]));
          check("stall_last", 32'(out_last_m), 32'(i == n - 1));
          check("stall_in_ready", 32'(in_ready_m), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      tick();
      check("valid_drop", 32'(out_valid_m), 32'd0);
      if (i == n - 1) check("in_ready_rise", 32'(in_ready_m), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] v [4];
    logic [15:0] e [4];
    logic [15:0] q4 [4];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel4 = 1'b1;
    q4 = '{16'd16384, 16'd16384, 16'd16384, 16'd16384};
    tick();
    tick();
    check("rst_in_ready4", 32'(in_ready4), 32'd0);
    check("rst_in_ready2", 32'(in_ready2), 32'd0);
    check("rst_out_valid4", 32'(out_valid4), 32'd0);
    check("rst_out_data4", 32'(out_data4), 32'd0);
    check("rst_out_last4", 32'(out_last4), 32'd0);
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
`ifdef SOFTMAX_ARGMAX_EN
    check("rst_argmax4", 32'(argmax4), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("in_ready4_after_rst", 32'(in_ready4), 32'd1);
    check("in_ready2_after_rst", 32'(in_ready2), 32'd1);

    // Equal logits: each term is a quarter of the sum
    v = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    send(4, v);
    recv(4, 4, q4, 0, -1, 0);

    // N=2, logits 0.0 and -1.0: LUT[16]=24109, sum=89644
    sel4 = 1'b0;
    v = '{16'h0000, 16'hff00, 16'h0000, 16'h0000};
    e = '{16'd47910, 16'd17625, 16'd0, 16'd0};
    send(2, v);
    recv(2, 2, e, 0, -1, 0);

    // N=2, gap of exactly 16.0: lower term underflows, the other saturates
    v = '{16'h0000, 16'h1000, 16'h0000, 16'h0000};
    e = '{16'd0, 16'd65535, 16'd0, 16'd0};
    send(2, v);
    recv(2, 2, e, 1, -1, 0);

    // N=4 with 5 stalled cycles on element 1; sum=2*65535+2*24109=179288
    sel4 = 1'b1;
    v = '{16'h0000, 16'hff00, 16'h0000, 16'hff00};
    e = '{16'd23955, 16'd8812, 16'd23955, 16'd8812};
    send(4, v);
    recv(4, 4, e, 0, 1, 5);

    // {3,7,7,1}: LUT[64]=1200, LUT[96]=162, sum=132432; first max at index 1
    v = '{16'h0300, 16'h0700, 16'h0700, 16'h0100};
    e = '{16'd593, 16'd32430, 16'd32430, 16'd80};
    send(4, v);
    recv(4, 4, e, 1, -1, 0);

    // Reset while element 2 is being divided, then a fresh vector
    v = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    send(4, v);
    recv(4, 2, q4, 0, -1, 0);
    tick();
    tick();
    tick();
    check("mid_div_valid", 32'(out_valid4), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(out_valid4), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready4), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready4), 32'd1);
    check("post_rst_valid", 32'(out_valid4), 32'd0);
    v = '{16'hfe00, 16'hfe00, 16'hfe00, 16'hfe00};
    send(4, v);
    recv(4, 4, q4, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
